// File: rtl/coremem_pkg.sv
// Shared constants, response encoding and address helper for the core-memory arbiter.
package coremem_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 16384;
    localparam int unsigned BE_W              = 4;

    typedef enum logic {
        RspOkay = 1'b0,
        RspErr  = 1'b1
    } rsp_e;

    // Zero-extended word index so the range check never truncates high address bits.
    function automatic logic [63:0] word_idx(input logic [63:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/coremem_rr_arb.sv
// Combinational round-robin picker: searches from ptr+1 upward and returns one-hot grant and index.
module coremem_rr_arb #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        int unsigned w_k;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_k = (32'(i_ptr) + i) % NREQ;
            if (!o_valid && i_req[IDX_W'(w_k)]) begin
                o_valid            = 1'b1;
                o_gnt[IDX_W'(w_k)] = 1'b1;
                o_idx              = IDX_W'(w_k);
            end
        end
    end

endmodule

// File: rtl/coremem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NREQ requesters; grant in the
// request cycle, response strobe exactly one cycle later, out-of-range accesses answered with err.
module coremem_arbiter
    import coremem_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    localparam int unsigned MEM_AW   = $clog2(MEM_WORDS),
    localparam int unsigned IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        we_i,
    input  logic [NREQ*BE_W-1:0]   be_i,
    input  logic [NREQ*ADDR_W-1:0] addr_i,
    input  logic [NREQ*DATA_W-1:0] wdata_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [NREQ-1:0]        rvalid_o,
    output logic                   err_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   mem_ce_o,
    output logic                   mem_we_o,
    output logic [MEM_AW-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    output logic [BE_W-1:0]        mem_be_o,
    input  logic [DATA_W-1:0]      mem_rdata_i
);

    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_rsp_own;
    logic              r_rsp_vld;
    logic              r_rsp_rd;
    rsp_e              r_rsp_err;

    logic [NREQ-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]  w_arb_idx;
    logic              w_arb_vld;
    logic              w_grant;
    logic              w_oor;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [BE_W-1:0]   w_sel_be;

    coremem_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .i_req   (req_i),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_vld)
    );

    // Reset masks the grant combinationally so nothing reaches the SRAM while rst_ni is low.
    assign w_grant = rst_ni & w_arb_vld;
    assign gnt_o   = rst_ni ? w_arb_gnt : '0;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        w_sel_we    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_o[k]) begin
                w_sel_addr  = addr_i[k*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata_i[k*DATA_W +: DATA_W];
                w_sel_be    = be_i[k*BE_W +: BE_W];
                w_sel_we    = we_i[k];
            end
        end
    end

    assign w_oor       = word_idx(64'(w_sel_addr)) >= 64'(MEM_WORDS);
    assign mem_ce_o    = w_grant & ~w_oor;
    assign mem_we_o    = mem_ce_o & w_sel_we;
    assign mem_addr_o  = w_sel_addr[MEM_AW+1:2];
    assign mem_wdata_o = w_sel_wdata;
    assign mem_be_o    = w_sel_be;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr  <= IDX_W'(NREQ - 1);
            r_rsp_vld <= 1'b0;
            r_rsp_rd  <= 1'b0;
            r_rsp_err <= RspOkay;
            r_rsp_own <= '0;
        end else begin
            r_rsp_vld <= w_grant;
            if (w_grant) begin
                r_rr_ptr  <= w_arb_idx;
                r_rsp_own <= w_arb_idx;
                r_rsp_rd  <= ~w_sel_we & ~w_oor;
                r_rsp_err <= w_oor ? RspErr : RspOkay;
            end
        end
    end

    // Gating with rst_ni drops a response that was in flight when reset arrived.
    always_comb begin
        rvalid_o = '0;
        if (rst_ni && r_rsp_vld) begin
            rvalid_o[r_rsp_own] = 1'b1;
        end
    end

    assign err_o   = rst_ni & r_rsp_vld & (r_rsp_err == RspErr);
    assign rdata_o = (rst_ni & r_rsp_vld & r_rsp_rd) ? mem_rdata_i : '0;

endmodule
